// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, masked, lowest-index-first interrupt controller with ack/EOI handshake
module irq_controller #(
    parameter int          NUM_SRC       = 4,
    parameter logic [15:0] BASE_ADDR     = 16'hFFF0,
    parameter logic [15:0] VECTOR_BASE   = 16'h0100,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic [NUM_SRC-1:0] src_reset_irq,
    output logic               cpu_irq,
    input  logic               cpu_reset_irq,
    output logic [15:0]        irq_vector,
    input  logic [15:0]        waddr,
    input  logic [15:0]        wdata,
    input  logic               wenable,
    input  logic [15:0]        raddr,
    output logic [15:0]        rdata
);

    typedef enum logic [1:0] {IDLE, REQUEST, ACK, IN_SERVICE} state_t;

    state_t             state, state_n;
    logic [NUM_SRC-1:0] mask, pending, pending_n, src_irq_q;
    logic [NUM_SRC-1:0] rise, req, ack_onehot;
    logic [3:0]         active_id, sel_id;
    logic               sel_found;
    logic [15:0]        sel_vector, woff, roff, rd_mux;
    logic               wr_mask, wr_pend, wr_eoi;
    logic               unused_wdata;

    assign woff    = waddr - BASE_ADDR;
    assign roff    = raddr - BASE_ADDR;
    assign wr_mask = wenable && (woff == 16'd0);
    assign wr_pend = wenable && (woff == 16'd1);
    assign wr_eoi  = wenable && (woff == 16'd3);
    assign unused_wdata = ^wdata;

    assign rise = src_irq & ~src_irq_q;
    assign req  = pending & mask;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_found = 1'b1;
                sel_id    = 4'(i);
            end
        end
    end

    assign sel_vector = VECTOR_BASE + 16'(sel_id) * VECTOR_STRIDE;

    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_onehot[i] = (active_id == 4'(i));
        end
    end

    // A new edge always wins over a W1C clear or the ack-time clear.
    always_comb begin
        pending_n = pending;
        if (wr_pend) begin
            pending_n = pending_n & ~wdata[NUM_SRC-1:0];
        end
        if (state == ACK) begin
            pending_n = pending_n & ~ack_onehot;
        end
        pending_n = pending_n | rise;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (sel_found)     state_n = REQUEST;
            REQUEST:    if (cpu_reset_irq) state_n = ACK;
            ACK:                           state_n = IN_SERVICE;
            IN_SERVICE: if (wr_eoi)        state_n = IDLE;
            default:                       state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (roff)
            16'd0:   rd_mux = 16'(mask);
            16'd1:   rd_mux = 16'(pending);
            16'd2:   rd_mux = {state == IN_SERVICE, cpu_irq, 10'b0, active_id};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            pending       <= '0;
            src_irq_q     <= '0;
            active_id     <= 4'd0;
            src_reset_irq <= '0;
            cpu_irq       <= 1'b0;
            irq_vector    <= 16'h0000;
            rdata         <= 16'h0000;
        end else begin
            state         <= state_n;
            src_irq_q     <= src_irq;
            pending       <= pending_n;
            rdata         <= rd_mux;
            cpu_irq       <= (state_n == REQUEST);
            src_reset_irq <= (state_n == ACK) ? ack_onehot : '0;
            if (wr_mask) begin
                mask <= wdata[NUM_SRC-1:0];
            end
            if (state == IDLE && sel_found) begin
                active_id  <= sel_id;
                irq_vector <= sel_vector;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    localparam logic [15:0] A_MASK = 16'hFFF0;
    localparam logic [15:0] A_PEND = 16'hFFF1;
    localparam logic [15:0] A_STAT = 16'hFFF2;
    localparam logic [15:0] A_EOI  = 16'hFFF3;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic [3:0]  src_reset_irq;
    logic        cpu_irq;
    logic        cpu_reset_irq;
    logic [15:0] irq_vector;
    logic [15:0] waddr, wdata, raddr, rdata;
    logic        wenable;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] rd;

    irq_controller dut (
        .clock(clock), .reset(reset), .src_irq(src_irq), .src_reset_irq(src_reset_irq),
        .cpu_irq(cpu_irq), .cpu_reset_irq(cpu_reset_irq), .irq_vector(irq_vector),
        .waddr(waddr), .wdata(wdata), .wenable(wenable), .raddr(raddr), .rdata(rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        waddr = a; wdata = d; wenable = 1'b1;
        tick();
        wenable = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d);
        raddr = a;
        tick();
        d = rdata;
    endtask

    task automatic ack_and_eoi();
        cpu_reset_irq = 1'b1;
        tick();
        cpu_reset_irq = 1'b0;
        tick();
        do_write(A_EOI, 16'h0000);
    endtask

    task automatic test_reset();
        reset = 1'b1; src_irq = 4'h0; cpu_reset_irq = 1'b0;
        waddr = 16'h0; wdata = 16'h0; wenable = 1'b0; raddr = 16'h0;
        tick(); tick();
        reset = 1'b0;
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL reset_cpu_irq got %h exp 0", cpu_irq); end
        compared++; if (irq_vector !== 16'h0000) begin mismatched++; $display("FAIL reset_vector got %h exp 0000", irq_vector); end
        compared++; if (src_reset_irq !== 4'h0) begin mismatched++; $display("FAIL reset_src_reset got %h exp 0", src_reset_irq); end
        do_read(A_MASK, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL reset_mask got %h exp 0000", rd); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL reset_pending got %h exp 0000", rd); end
    endtask

    task automatic test_single();
        do_write(A_MASK, 16'h000F);
        src_irq = 4'b0100;
        tick();
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL single_irq_early got %h exp 0", cpu_irq); end
        tick();
        src_irq = 4'b0000;
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL single_irq got %h exp 1", cpu_irq); end
        compared++; if (irq_vector !== 16'h0120) begin mismatched++; $display("FAIL single_vector got %h exp 0120", irq_vector); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0004) begin mismatched++; $display("FAIL single_pending got %h exp 0004", rd); end
        do_read(A_STAT, rd);
        compared++; if (rd !== 16'h4002) begin mismatched++; $display("FAIL single_status got %h exp 4002", rd); end
        do_read(16'hFFF7, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL single_oor_read got %h exp 0000", rd); end
        cpu_reset_irq = 1'b1;
        tick();
        cpu_reset_irq = 1'b0;
        compared++; if (src_reset_irq !== 4'b0100) begin mismatched++; $display("FAIL single_src_reset got %h exp 4", src_reset_irq); end
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL single_irq_after_ack got %h exp 0", cpu_irq); end
        tick();
        do_read(A_STAT, rd);
        compared++; if (rd !== 16'h8002) begin mismatched++; $display("FAIL single_status_is got %h exp 8002", rd); end
        do_write(A_EOI, 16'h1234);
        tick();
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL single_idle_after_eoi got %h exp 0", cpu_irq); end
    endtask

    task automatic test_priority();
        src_irq = 4'b1010;
        tick(); tick();
        src_irq = 4'b0000;
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL prio_irq got %h exp 1", cpu_irq); end
        compared++; if (irq_vector !== 16'h0110) begin mismatched++; $display("FAIL prio_vector got %h exp 0110", irq_vector); end
        cpu_reset_irq = 1'b1;
        tick();
        cpu_reset_irq = 1'b0;
        compared++; if (src_reset_irq !== 4'b0010) begin mismatched++; $display("FAIL prio_src_reset got %h exp 2", src_reset_irq); end
        tick();
        compared++; if (src_reset_irq !== 4'b0000) begin mismatched++; $display("FAIL prio_src_reset_one_cycle got %h exp 0", src_reset_irq); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0008) begin mismatched++; $display("FAIL prio_pending got %h exp 0008", rd); end
        do_write(A_EOI, 16'h0000);
        tick();
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL prio_next_irq got %h exp 1", cpu_irq); end
        compared++; if (irq_vector !== 16'h0130) begin mismatched++; $display("FAIL prio_next_vector got %h exp 0130", irq_vector); end
        ack_and_eoi();
    endtask

    task automatic test_mask();
        do_write(A_MASK, 16'h0000);
        src_irq = 4'b0001;
        tick();
        src_irq = 4'b0000;
        tick(); tick();
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL mask_blocked got %h exp 0", cpu_irq); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0001) begin mismatched++; $display("FAIL mask_pending got %h exp 0001", rd); end
        do_write(A_MASK, 16'h0001);
        tick();
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL mask_enable_irq got %h exp 1", cpu_irq); end
        do_write(A_PEND, 16'h0001);
        do_write(A_MASK, 16'h0000);
        tick(); tick();
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL mask_request_persists got %h exp 1", cpu_irq); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL mask_w1c got %h exp 0000", rd); end
        ack_and_eoi();
    endtask

    task automatic test_in_service();
        do_write(A_MASK, 16'h000F);
        src_irq = 4'b1000;
        tick(); tick();
        src_irq = 4'b0000;
        cpu_reset_irq = 1'b1;
        tick();
        cpu_reset_irq = 1'b0;
        tick();
        src_irq = 4'b0001;
        tick();
        src_irq = 4'b0000;
        tick(); tick(); tick();
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL is_no_nesting got %h exp 0", cpu_irq); end
        do_read(A_STAT, rd);
        compared++; if (rd !== 16'h8003) begin mismatched++; $display("FAIL is_status got %h exp 8003", rd); end
        do_write(A_EOI, 16'h0000);
        tick();
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL is_after_eoi got %h exp 1", cpu_irq); end
        compared++; if (irq_vector !== 16'h0100) begin mismatched++; $display("FAIL is_vector got %h exp 0100", irq_vector); end
        ack_and_eoi();
        do_write(A_EOI, 16'h0000);
        tick();
        do_read(A_STAT, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL idle_eoi_status got %h exp 0000", rd); end
        do_write(A_MASK, 16'h0000);
        src_irq = 4'b0010;
        repeat (100) tick();
        do_write(A_PEND, 16'h0002);
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL held_high_once got %h exp 0000", rd); end
        src_irq = 4'b0000;
        tick();
    endtask

    task automatic test_collision();
        src_irq = 4'b0100;
        do_write(A_PEND, 16'h0004);
        src_irq = 4'b0000;
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0004) begin mismatched++; $display("FAIL collision_set_wins got %h exp 0004", rd); end
        do_write(A_PEND, 16'h0004);
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL collision_clear got %h exp 0000", rd); end
    endtask

    task automatic test_reset_mid();
        do_write(A_MASK, 16'h0005);
        do_write(16'hFFF4, 16'hFFFF);
        do_read(A_MASK, rd);
        compared++; if (rd !== 16'h0005) begin mismatched++; $display("FAIL oor_write_ignored got %h exp 0005", rd); end
        src_irq = 4'b0100;
        tick(); tick();
        src_irq = 4'b0000;
        compared++; if (cpu_irq !== 1'b1) begin mismatched++; $display("FAIL mid_pre_irq got %h exp 1", cpu_irq); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++; if (cpu_irq !== 1'b0) begin mismatched++; $display("FAIL mid_irq got %h exp 0", cpu_irq); end
        compared++; if (irq_vector !== 16'h0000) begin mismatched++; $display("FAIL mid_vector got %h exp 0000", irq_vector); end
        do_read(A_PEND, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL mid_pending got %h exp 0000", rd); end
        do_read(A_MASK, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL mid_mask got %h exp 0000", rd); end
        do_read(A_STAT, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL mid_status got %h exp 0000", rd); end
        do_read(16'hFFF7, rd);
        compared++; if (rd !== 16'h0000) begin mismatched++; $display("FAIL mid_oor_read got %h exp 0000", rd); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_in_service();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller between the peripheral drivers (keyboard, VGA, future devices) and the CPU irq/reset_irq pair.
- Latches rising edges of per-device irq lines into a pending register, applies a mask, and selects the lowest-index pending source.
- Presents a single irq plus a service vector to the control path and runs the acknowledge / end-of-interrupt handshake.
- Returns a one-cycle reset_irq pulse to the serviced device.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- BASE_ADDR, 16'hFFF0, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
- VECTOR_BASE, 16'h0100, vector for source 0.
- VECTOR_STRIDE, 16'h0010, vector spacing per source.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- src_irq  in  NUM_SRC  per-device irq level.
- src_reset_irq  out  NUM_SRC  one-cycle clear pulse to the serviced device.
- cpu_irq  out  1  interrupt request to the control path.
- cpu_reset_irq  in  1  acknowledge from the control path; sampled as a level.
- irq_vector  out  16  jump target for the active source.
- waddr  in  16  CPU write address.
- wdata  in  16  CPU write data.
- wenable  in  1  CPU write strobe.
- raddr  in  16  CPU read address.
- rdata  out  16  read data, registered.

Behaviour:
- Reset (clock edge with reset=1) clears:
  - mask, pending, src_irq_q, active_id, src_reset_irq, cpu_irq, rdata, irq_vector;
  - state returns to IDLE.
  - This applies mid-handshake; an in-flight request is discarded.
- Edge capture:
  - src_irq_q <= src_irq every cycle.
  - pending[i] is set at any edge where src_irq[i]=1 and src_irq_q[i]=0.
  - A held-high level sets pending only once.
- Register map (offset from BASE_ADDR):
  - 0 MASK: RW; bit i=1 enables source i.
  - 1 PENDING: read returns pending. Write is W1C: pending &= ~wdata.
  - 2 STATUS: read only. [15]=in_service, [14]=request, [3:0]=active_id, other bits 0.
  - 3 EOI: write-only, any data; reads return 0.
- Bits at or above NUM_SRC read 0 and ignore writes. Out-of-range addresses read 0; writes to them are ignored.
- rdata is valid one cycle after raddr is presented.
- Set/clear collision: if an edge and a W1C clear hit the same bit in the same cycle, set wins and pending stays 1.
- FSM states: IDLE, REQUEST, ACK, IN_SERVICE.
  - IDLE:
    - If (pending & mask) != 0, latch active_id = lowest set index and irq_vector = VECTOR_BASE + active_id*VECTOR_STRIDE (16-bit wrap), then go to REQUEST.
    - cpu_irq rises on the same edge, so it is registered.
  - REQUEST:
    - cpu_irq=1; active_id and vector are frozen.
    - MASK or PENDING changes do not retract the request.
    - When cpu_reset_irq=1, go to ACK and clear cpu_irq.
  - ACK (exactly one cycle):
    - src_reset_irq[active_id]=1; pending[active_id] cleared unless a new edge arrives that cycle.
    - Go to IN_SERVICE.
  - IN_SERVICE:
    - cpu_irq=0; no new request, no nesting.
    - An EOI write (wenable and waddr=BASE_ADDR+3) returns to IDLE.
    - EOI writes in any other state are ignored.
- Latency: an edge sampled at edge N sets pending at N; cpu_irq is high after edge N+1 when masked-in and the FSM is IDLE. After EOI, the next pending source is requested after one more edge.
- src_reset_irq is zero outside ACK.
- irq_vector holds its last value outside REQUEST/ACK/IN_SERVICE.

Test Plan:
- Reset, MASK=0x000F, pulse src_irq[2] -> PENDING reads 0x0004; cpu_irq=1 two edges after src rise; irq_vector=0x0120; STATUS=0x4002.
- src_irq[1] and src_irq[3] rise together -> active_id=1, vector 0x0110. Then ack -> src_reset_irq=0b0010 for exactly one cycle, PENDING=0x0008. Then write EOI -> cpu_irq=1 with vector 0x0130.
- MASK=0x0000, pulse src_irq[0] -> PENDING=0x0001, cpu_irq stays 0. Write MASK=0x0001 -> cpu_irq=1 next cycle. Write PENDING=0x0001 during REQUEST -> request persists until ack.
- In IN_SERVICE, raise src_irq[0] -> no cpu_irq until EOI. EOI written in IDLE -> no effect. src_irq held high 100 cycles -> pending set once.
- Same-cycle W1C of bit 2 and a src_irq[2] rising edge -> PENDING bit 2 = 1.
- Assert reset during REQUEST -> next cycle cpu_irq=0, PENDING=0, MASK=0, STATUS=0. Read BASE_ADDR+7 -> rdata=0x0000.
